// File: rtl/pipe_wb_buf.sv
// In-order writeback retire buffer between MEM and the register file.
// Provides bypass lookup over buffered results and precise exception retirement with flush.
module pipe_wb_buf #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned RDC_W      = 5,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned NUM_LOOKUP = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           mem_wb_validto,
    output logic                           wb_allowin,
    input  logic [DATA_W-1:0]              wb_result_in,
    input  logic [RDC_W-1:0]               rdc_in,
    input  logic                           rf_we_in,
    input  logic                           ex_in,
    input  logic [4:0]                     ex_code_in,
    input  logic [31:0]                    pc_in,
    input  logic                           rf_stall,
    output logic                           rf_we,
    output logic [RDC_W-1:0]               rdc_wb,
    output logic [DATA_W-1:0]              wb_result,
    output logic                           ex,
    output logic [4:0]                     ex_code,
    output logic [31:0]                    epc_out,
    input  logic [NUM_LOOKUP*RDC_W-1:0]    query_rdc,
    output logic [NUM_LOOKUP-1:0]          bypass_hit,
    output logic [NUM_LOOKUP*DATA_W-1:0]   bypass_data,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [DATA_W-1:0] ent_result_q [DEPTH];
    logic [RDC_W-1:0]  ent_rdc_q    [DEPTH];
    logic              ent_we_q     [DEPTH];
    logic              ent_ex_q     [DEPTH];
    logic [4:0]        ent_code_q   [DEPTH];
    logic [31:0]       ent_pc_q     [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ex_q, ex_d;
    logic [4:0]       ex_code_q, ex_code_d;
    logic [31:0]      epc_q, epc_d;

    logic head_valid;
    logic push;
    logic norm_retire;
    logic ex_retire;

    // Full is judged on registered occupancy only, so a same-cycle retire never opens a slot.
    assign wb_allowin  = (count_q != CNT_W'(DEPTH));
    assign head_valid  = (count_q != '0);
    assign push        = mem_wb_validto && wb_allowin;
    assign ex_retire   = head_valid && ent_ex_q[head_q];
    assign norm_retire = head_valid && !ent_ex_q[head_q] && !rf_stall;

    assign rf_we     = norm_retire && ent_we_q[head_q];
    assign rdc_wb    = ent_rdc_q[head_q];
    assign wb_result = ent_result_q[head_q];

    assign ex      = ex_q;
    assign ex_code = ex_code_q;
    assign epc_out = epc_q;
    assign count   = count_q;

    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        ex_d      = 1'b0;
        ex_code_d = ex_code_q;
        epc_d     = epc_q;
        if (ex_retire) begin
            head_d    = '0;
            tail_d    = '0;
            count_d   = '0;
            ex_d      = 1'b1;
            ex_code_d = ent_code_q[head_q];
            epc_d     = ent_pc_q[head_q];
        end else begin
            if (push)        tail_d = tail_q + PTR_W'(1);
            if (norm_retire) head_d = head_q + PTR_W'(1);
            if (push && !norm_retire)      count_d = count_q + CNT_W'(1);
            else if (!push && norm_retire) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            ex_q      <= 1'b0;
            ex_code_q <= '0;
            epc_q     <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            ex_q      <= ex_d;
            ex_code_q <= ex_code_d;
            epc_q     <= epc_d;
        end
    end

    // Payload storage carries no reset; validity is tracked solely by count/head/tail.
    always_ff @(posedge clk) begin
        if (push && !ex_retire) begin
            ent_result_q[tail_q] <= wb_result_in;
            ent_rdc_q[tail_q]    <= rdc_in;
            ent_we_q[tail_q]     <= rf_we_in;
            ent_ex_q[tail_q]     <= ex_in;
            ent_code_q[tail_q]   <= ex_code_in;
            ent_pc_q[tail_q]     <= pc_in;
        end
    end

    // Scan oldest to youngest so the last match (youngest) overrides earlier ones.
    always_comb begin
        logic [PTR_W-1:0] idx;
        logic [RDC_W-1:0] q;
        idx         = '0;
        q           = '0;
        bypass_hit  = '0;
        bypass_data = '0;
        for (int unsigned i = 0; i < NUM_LOOKUP; i++) begin
            q = query_rdc[i*RDC_W +: RDC_W];
            for (int unsigned k = 0; k < DEPTH; k++) begin
                idx = head_q + PTR_W'(k);
                if ((CNT_W'(k) < count_q) && ent_we_q[idx] && !ent_ex_q[idx] &&
                    (ent_rdc_q[idx] == q) && (q != '0)) begin
                    bypass_hit[i]                     = 1'b1;
                    bypass_data[i*DATA_W +: DATA_W]   = ent_result_q[idx];
                end
            end
        end
    end

endmodule
